lda_line_engine: RTL and testbench

LDA_LINE_ENGINE -- requirements
Module: lda_line_engine

---
 rtl/lda_line_engine.sv | 197 +++++++++++++++++++
 tb/tb_lda_line_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lda_line_engine.sv
// lda_line_engine
//   Bresenham line rasteriser. A start pulse latches two endpoints and a colour.
//   One SETUP cycle folds the line into a shallow, left-to-right form.
//   DRAW then emits one pixel per accepted transfer.
//   DONE raises a one-cycle completion pulse.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   i_data_reset              synchronous return to IDLE (beats every other input)
//   i_start_draw_line         start pulse, honoured only in IDLE
//   i_draw_line               level that lets DRAW present/step pixels
//   i_x0/i_y0, i_x1/i_y1      endpoints; i_color line colour
//   o_plot / i_plot_ready     pixel handshake (see below)
//   o_x, o_y, o_color         pixel being offered
//   o_line_done               one-cycle pulse after the last pixel is accepted
//   dbg_state                 current FSM state (0 IDLE, 1 SETUP, 2 DRAW, 3 DONE)
//
// Handshake: a pixel transfers on a rising edge where o_plot and i_plot_ready
// are both high. o_x/o_y/o_color stay stable while o_plot is high and
// i_plot_ready is low. o_plot does not wait for i_plot_ready.
//
// Optional feature: define LDA_LINE_ENGINE_CLIP_EN to suppress pixels outside
// XMAX x YMAX. The engine still steps through those pixels without waiting for
// i_plot_ready.
module lda_line_engine #(
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int CW   = 3,
    parameter int XMAX = 336,
    parameter int YMAX = 210
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_data_reset,
    input  logic          i_start_draw_line,
    input  logic          i_draw_line,
    input  logic [XW-1:0] i_x0,
    input  logic [XW-1:0] i_x1,
    input  logic [YW-1:0] i_y0,
    input  logic [YW-1:0] i_y1,
    input  logic [CW-1:0] i_color,
    output logic          o_plot,
    input  logic          i_plot_ready,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [CW-1:0] o_color,
    output logic          o_line_done,
    output logic [1:0]    dbg_state
);

    localparam int AW = 11;  // signed working width for dx, dy, err

`ifdef LDA_LINE_ENGINE_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    localparam logic [XW-1:0] XMAX_X = XW'(XMAX);
    localparam logic [YW-1:0] YMAX_Y = YW'(YMAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic [XW-1:0] lx0, lx1;
    logic [YW-1:0] ly0, ly1;
    logic [CW-1:0] col;

    // cur_a runs along the major axis and cur_b along the minor axis.
    // Both are XW wide because a steep line puts x values on the minor axis.
    logic                 steep;
    logic                 ystep_neg;
    logic [XW-1:0]        cur_a, cur_b, end_a;
    logic signed [AW-1:0] dx, dy, err;

    // ---------------- setup arithmetic on the latched endpoints --------------
    logic signed [AW-1:0] sx0, sx1, sy0, sy1, adx, ady;
    logic signed [AW-1:0] a0, b0, a1, b1, pa0, pb0, pa1, pb1;
    logic signed [AW-1:0] dx_c, dy_c, err_c;
    logic                 steep_c, swap_c, ystep_neg_c;

    assign sx0 = $signed({{(AW-XW){1'b0}}, lx0});
    assign sx1 = $signed({{(AW-XW){1'b0}}, lx1});
    assign sy0 = $signed({{(AW-YW){1'b0}}, ly0});
    assign sy1 = $signed({{(AW-YW){1'b0}}, ly1});

    assign adx     = (sx1 >= sx0) ? sx1 - sx0 : sx0 - sx1;
    assign ady     = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
    assign steep_c = ady > adx;

    // A steep line swaps its axes so that it always steps along a.
    assign a0 = steep_c ? sy0 : sx0;
    assign b0 = steep_c ? sx0 : sy0;
    assign a1 = steep_c ? sy1 : sx1;
    assign b1 = steep_c ? sx1 : sy1;

    // Swap the endpoints so that a increases along the line.
    assign swap_c = a0 > a1;
    assign pa0    = swap_c ? a1 : a0;
    assign pb0    = swap_c ? b1 : b0;
    assign pa1    = swap_c ? a0 : a1;
    assign pb1    = swap_c ? b0 : b1;

    assign dx_c        = pa1 - pa0;
    assign dy_c        = (pb1 >= pb0) ? pb1 - pb0 : pb0 - pb1;
    assign ystep_neg_c = pb1 < pb0;
    assign err_c       = -(dx_c >>> 1);

    // ---------------- per-pixel step ----------------------------------------
    logic signed [AW-1:0] err_dy;
    logic                 step_b, clipped, advance, last_px;

    assign err_dy  = err + dy;
    assign step_b  = !err_dy[AW-1];  // err + dy >= 0
    assign last_px = (cur_a == end_a);

    // Output mapping undoes the steep swap.
    assign o_x     = steep ? cur_b : cur_a;
    assign o_y     = steep ? cur_a[YW-1:0] : cur_b[YW-1:0];
    assign o_color = col;

    assign clipped = CLIP_EN && ((o_x >= XMAX_X) || (o_y >= YMAX_Y));

    // o_plot follows i_draw_line combinationally while in DRAW.
    assign o_plot      = (state == DRAW) && i_draw_line && !clipped;
    assign advance     = (state == DRAW) && i_draw_line && (i_plot_ready || clipped);
    assign o_line_done = (state == DONE);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lx0       <= '0;
            lx1       <= '0;
            ly0       <= '0;
            ly1       <= '0;
            col       <= '0;
            steep     <= 1'b0;
            ystep_neg <= 1'b0;
            cur_a     <= '0;
            cur_b     <= '0;
            end_a     <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
        end else if (i_data_reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start_draw_line) begin
                        lx0   <= i_x0;
                        ly0   <= i_y0;
                        lx1   <= i_x1;
                        ly1   <= i_y1;
                        col   <= i_color;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    steep     <= steep_c;
                    ystep_neg <= ystep_neg_c;
                    cur_a     <= pa0[XW-1:0];
                    cur_b     <= pb0[XW-1:0];
                    end_a     <= pa1[XW-1:0];
                    dx        <= dx_c;
                    dy        <= dy_c;
                    err       <= err_c;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (last_px) begin
                            state <= DONE;
                        end else begin
                            cur_a <= cur_a + XW'(1);
                            if (step_b) begin
                                cur_b <= ystep_neg ? cur_b - XW'(1) : cur_b + XW'(1);
                                err   <= err_dy - dx;
                            end else begin
                                err <= err_dy;
                            end
                        end
                    end
                end
                default: state <= IDLE;  // DONE lasts one cycle
            endcase
        end
    end

endmodule

// File: tb/tb_lda_line_engine.sv
module tb_lda_line_engine;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_data_reset = 1'b0;
    logic          i_start_draw_line = 1'b0;
    logic          i_draw_line = 1'b0;
    logic [XW-1:0] i_x0 = '0, i_x1 = '0;
    logic [YW-1:0] i_y0 = '0, i_y1 = '0;
    logic [CW-1:0] i_color = '0;
    logic          i_plot_ready = 1'b0;
    logic          o_plot, o_line_done;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic [CW-1:0] o_color;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    lda_line_engine dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_data_reset     (i_data_reset),
        .i_start_draw_line(i_start_draw_line),
        .i_draw_line      (i_draw_line),
        .i_x0             (i_x0),
        .i_x1             (i_x1),
        .i_y0             (i_y0),
        .i_y1             (i_y1),
        .i_color          (i_color),
        .o_plot           (o_plot),
        .i_plot_ready     (i_plot_ready),
        .o_x              (o_x),
        .o_y              (o_y),
        .o_color          (o_color),
        .o_line_done      (o_line_done),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock ---------------------------------------------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking and driver tasks ------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input int x0, input int y0, input int x1, input int y1, input int c);
        i_x0 = XW'(x0);
        i_y0 = YW'(y0);
        i_x1 = XW'(x1);
        i_y1 = YW'(y1);
        i_color = CW'(c);
        i_start_draw_line = 1'b1;
        cyc();
        i_start_draw_line = 1'b0;
        @(negedge clk);
        chk("setup_state", dbg_state, 1);
        chk("setup_plot", o_plot, 0);
        cyc();
    endtask

    task automatic px(input string tag, input int x, input int y, input int c);
        @(negedge clk);
        chk({tag, "_plot"}, o_plot, 1);
        chk({tag, "_x"}, o_x, x);
        chk({tag, "_y"}, o_y, y);
        chk({tag, "_color"}, o_color, c);
        cyc();
    endtask

    task automatic done_chk(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, o_line_done, 1);
        chk({tag, "_done_plot"}, o_plot, 0);
        cyc();
        @(negedge clk);
        chk({tag, "_idle_state"}, dbg_state, 0);
        chk({tag, "_idle_done"}, o_line_done, 0);
        cyc();
    endtask

    // ---------------- directed sequence --------------------------------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", dbg_state, 0);
        chk("rst_plot", o_plot, 0);
        chk("rst_done", o_line_done, 0);
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        chk("rst_color", o_color, 0);
        cyc();
        reset_n = 1'b1;
        i_draw_line = 1'b1;
        i_plot_ready = 1'b1;
        cyc();

        // Horizontal line: one pixel per cycle, then done.
        start_line(0, 0, 3, 0, 5);
        px("h0", 0, 0, 5);
        px("h1", 1, 0, 5);
        px("h2", 2, 0, 5);
        px("h3", 3, 0, 5);
        done_chk("h");

        // Steep line.
        start_line(0, 0, 1, 3, 6);
        px("s0", 0, 0, 6);
        px("s1", 1, 1, 6);
        px("s2", 1, 2, 6);
        px("s3", 1, 3, 6);
        done_chk("s");

        // Reversed endpoints are swapped.
        start_line(3, 0, 0, 0, 1);
        px("r0", 0, 0, 1);
        px("r1", 1, 0, 1);
        px("r2", 2, 0, 1);
        px("r3", 3, 0, 1);
        done_chk("r");

        // Degenerate single-pixel line.
        start_line(5, 5, 5, 5, 2);
        px("d0", 5, 5, 2);
        done_chk("d");

        // Diagonal with decreasing y.
        start_line(0, 3, 3, 0, 7);
        px("n0", 0, 3, 7);
        px("n1", 1, 2, 7);
        px("n2", 2, 1, 7);
        px("n3", 3, 0, 7);
        done_chk("n");

        // Steep line with reversed endpoints.
        start_line(2, 4, 0, 0, 3);
        px("sr0", 0, 0, 3);
        px("sr1", 1, 1, 3);
        px("sr2", 1, 2, 3);
        px("sr3", 2, 3, 3);
        px("sr4", 2, 4, 3);
        done_chk("sr");

        // Backpressure at (1,1), a start pulse during DRAW, and a draw_line gap.
        start_line(0, 0, 3, 3, 4);
        px("bp0", 0, 0, 4);
        i_plot_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                i_x0 = 9'd100;
                i_y0 = 8'd50;
                i_color = 3'd1;
                i_start_draw_line = 1'b1;
            end else begin
                i_start_draw_line = 1'b0;
            end
            px("bp_hold", 1, 1, 4);
        end
        i_start_draw_line = 1'b0;
        i_draw_line = 1'b0;
        @(negedge clk);
        chk("gap_plot", o_plot, 0);
        chk("gap_x", o_x, 1);
        cyc();
        i_draw_line = 1'b1;
        i_plot_ready = 1'b1;
        px("bp1", 1, 1, 4);
        px("bp2", 2, 2, 4);
        px("bp3", 3, 3, 4);
        done_chk("bp");

        // Asynchronous reset during the second pixel of a 10-pixel line.
        start_line(0, 0, 9, 0, 2);
        px("ar0", 0, 0, 2);
        @(negedge clk);
        chk("ar1_plot", o_plot, 1);
        chk("ar1_x", o_x, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_plot", o_plot, 0);
        chk("ar_state", dbg_state, 0);
        chk("ar_x", o_x, 0);
        #2;
        reset_n = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_nodone", o_line_done, 0);
            chk("ar_noplot", o_plot, 0);
            cyc();
        end
        start_line(2, 1, 4, 2, 6);
        px("ar_new0", 2, 1, 6);
        px("ar_new1", 3, 2, 6);
        px("ar_new2", 4, 2, 6);
        done_chk("ar_new");

        // Synchronous data reset mid-line; outputs hold in IDLE.
        start_line(0, 0, 5, 0, 3);
        px("dr0", 0, 0, 3);
        i_data_reset = 1'b1;
        cyc();
        i_data_reset = 1'b0;
        @(negedge clk);
        chk("dr_state", dbg_state, 0);
        chk("dr_plot", o_plot, 0);
        chk("dr_done", o_line_done, 0);
        chk("dr_hold_x", o_x, 1);
        chk("dr_hold_color", o_color, 3);
        cyc();
        @(negedge clk);
        chk("dr_nodone", o_line_done, 0);
        cyc();

`ifdef LDA_LINE_ENGINE_CLIP_EN
        // Clipped pixels step without i_plot_ready.
        start_line(334, 0, 337, 0, 5);
        px("c0", 334, 0, 5);
        px("c1", 335, 0, 5);
        i_plot_ready = 1'b0;
        @(negedge clk);
        chk("c2_plot", o_plot, 0);
        chk("c2_x", o_x, 336);
        cyc();
        @(negedge clk);
        chk("c3_plot", o_plot, 0);
        chk("c3_x", o_x, 337);
        cyc();
        done_chk("c");
        i_plot_ready = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
